// File: rtl/reg_shift_seq_if.sv
// Bundles the command port and the register-side port of the reg_8bit sequencer.
interface reg_shift_seq_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             start;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_arith;
    logic [AMT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] reg_q;
    logic [1:0]       reg_f;
    logic [WIDTH-1:0] reg_d;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    // Handshake: start is taken on any edge where busy=0; it is ignored (not queued) while busy=1.
    // done pulses for one cycle with result valid; start may be raised in that same cycle.
    modport master (
        output start, cmd_data, cmd_arith, cmd_amt, reg_q,
        input  reg_f, reg_d, busy, done, result
    );

    modport slave (
        input  start, cmd_data, cmd_arith, cmd_amt, reg_q,
        output reg_f, reg_d, busy, done, result
    );
endinterface

// File: rtl/reg_shift_seq.sv
// Sequencer for reg_8bit: one load cycle, amt one-bit right shifts, then capture of the result.
module reg_shift_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic           clock,
    input  logic           reset,
    reg_shift_seq_if.slave bus,
    output logic [1:0]     dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_SHIFT   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             arith_q,  arith_d;
    logic [AMT_W-1:0] amt_q,    amt_d;
    logic [AMT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q,   done_d;
    logic [1:0]       reg_f_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            arith_q  <= 1'b0;
            amt_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            arith_q  <= arith_d;
            amt_q    <= amt_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // reg_f depends only on registered state, so the register never sees a glitching function.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        arith_d  = arith_q;
        amt_d    = amt_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        reg_f_c  = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    data_d  = bus.cmd_data;
                    arith_d = bus.cmd_arith;
                    amt_d   = bus.cmd_amt;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                reg_f_c = 2'b01;
                cnt_d   = amt_q;
                state_d = (amt_q != '0) ? S_SHIFT : S_CAPTURE;
            end
            S_SHIFT: begin
                reg_f_c = {1'b1, arith_q};
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                result_d = bus.reg_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.reg_f    = reg_f_c;
    assign bus.reg_d    = data_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_reg_shift_seq.sv
// Directed + random bench for reg_shift_seq with a behavioural reg_8bit and a result scoreboard.
module tb_reg_shift_seq;
    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic       clock;
    logic       reset;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;
    logic [WIDTH-1:0] exp_q[$];

    reg_shift_seq_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) sif ();

    reg_shift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (sif.slave),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=still running expected=finished");
        $fatal(1, "timeout");
    end

    // reg_8bit behaviour, sharing the sequencer's reset
    always_ff @(posedge clock) begin
        if (reset) begin
            sif.reg_q <= '0;
        end else begin
            case (sif.reg_f)
                2'b01:   sif.reg_q <= sif.reg_d;
                2'b10:   sif.reg_q <= {1'b0, sif.reg_q[WIDTH-1:1]};
                2'b11:   sif.reg_q <= {sif.reg_q[WIDTH-1], sif.reg_q[WIDTH-1:1]};
                default: sif.reg_q <= sif.reg_q;
            endcase
        end
    end

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic a, input int n);
        logic [WIDTH-1:0] r;
        r = d;
        for (int i = 0; i < n; i++) r = {a & r[WIDTH-1], r[WIDTH-1:1]};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every done pulse pops one expected result
    always @(negedge clock) begin
        if (!reset && sif.done === 1'b1) begin
            done_seen++;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL done_no_cmd observed=done pulse expected=no pulse");
            end
            if (exp_q.size() > 0) chk("result", 32'(sif.result), 32'(exp_q.pop_front()));
        end
    end

    // Called on a negedge; issues a command and checks every cycle until the done cycle.
    // intrude=k (1..n+1) raises a stray 8'h0F start at cycle k; 0 means none.
    task automatic run_cmd(input logic [WIDTH-1:0] d, input logic a, input int n, input int intrude);
        logic [1:0] ef;
        int busy_cnt;
        busy_cnt = 0;
        sif.start     = 1'b1;
        sif.cmd_data  = d;
        sif.cmd_arith = a;
        sif.cmd_amt   = AMT_W'(n);
        exp_q.push_back(model(d, a, n));
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clock);
            if (k == 1)          ef = 2'b01;
            else if (k <= n + 1) ef = {1'b1, a};
            else                 ef = 2'b00;
            chk("reg_f", 32'(sif.reg_f), 32'(ef));
            chk("reg_d", 32'(sif.reg_d), 32'(d));
            chk("busy",  32'(sif.busy),  32'(k <= n + 2));
            chk("done",  32'(sif.done),  32'(k == n + 3));
            if (k == n + 2) chk("reg_q_at_capture", 32'(sif.reg_q), 32'(model(d, a, n)));
            if (sif.busy === 1'b1) busy_cnt++;
            if (k == 1) begin
                sif.start     = 1'b0;
                sif.cmd_data  = WIDTH'($urandom_range(0, 255));
                sif.cmd_arith = 1'($urandom_range(0, 1));
                sif.cmd_amt   = AMT_W'($urandom_range(0, 7));
            end
            if (k == intrude) begin
                sif.start     = 1'b1;
                sif.cmd_data  = 8'h0F;
                sif.cmd_arith = ~a;
                sif.cmd_amt   = AMT_W'(n ^ 1);
            end else if (intrude != 0 && k == intrude + 1) begin
                sif.start = 1'b0;
            end
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(n + 2));
    endtask

    initial begin
        int d_seen;
        int n_r;
        reset         = 1'b1;
        sif.start     = 1'b0;
        sif.cmd_data  = '0;
        sif.cmd_arith = 1'b0;
        sif.cmd_amt   = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy",   32'(sif.busy),   32'd0);
        chk("rst_done",   32'(sif.done),   32'd0);
        chk("rst_result", 32'(sif.result), 32'd0);
        chk("rst_reg_f",  32'(sif.reg_f),  32'd0);
        chk("rst_reg_d",  32'(sif.reg_d),  32'd0);
        chk("rst_state",  32'(dbg_state),  32'd0);
        reset = 1'b0;
        @(negedge clock);

        // directed commands, each issued in the done cycle of the previous one
        run_cmd(8'hAA, 1'b0, 0, 0);
        run_cmd(8'hAA, 1'b1, 1, 0);
        run_cmd(8'hAA, 1'b0, 3, 0);
        run_cmd(8'h80, 1'b1, 7, 0);
        run_cmd(8'h80, 1'b0, 7, 0);

        for (int i = 0; i < 8; i++) begin
            n_r = $urandom_range(0, 7);
            run_cmd(WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), n_r,
                    $urandom_range(0, n_r + 1));
        end

        // stray start during busy, then back-to-back accept in the done cycle
        run_cmd(8'hAA, 1'b1, 7, 3);
        run_cmd(8'h3C, 1'b0, 2, 1);
        run_cmd(8'hC3, 1'b1, 2, 0);

        repeat (3) begin
            @(negedge clock);
            chk("idle_done", 32'(sif.done), 32'd0);
            chk("idle_busy", 32'(sif.busy), 32'd0);
        end
        chk("result_holds", 32'(sif.result), 32'hF0);

        // reset in the middle of a shift sequence
        sif.start     = 1'b1;
        sif.cmd_data  = 8'hAA;
        sif.cmd_arith = 1'b0;
        sif.cmd_amt   = 3'd5;
        @(negedge clock);
        sif.start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("pre_rst_state", 32'(dbg_state), 32'd2);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_busy",   32'(sif.busy),   32'd0);
        chk("mid_rst_done",   32'(sif.done),   32'd0);
        chk("mid_rst_result", 32'(sif.result), 32'd0);
        chk("mid_rst_reg_f",  32'(sif.reg_f),  32'd0);
        chk("mid_rst_reg_q",  32'(sif.reg_q),  32'd0);
        chk("mid_rst_state",  32'(dbg_state),  32'd0);
        reset = 1'b0;
        d_seen = done_seen;
        repeat (12) @(negedge clock);
        chk("no_done_after_rst", 32'(done_seen), 32'(d_seen));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
